// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: op codes, FSM states and HI/LO write-bus layout shared by hilo_muldiv
package hilo_muldiv_pkg;
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int HILO_BUS_WD = 66;
  localparam int BUS_HI_WE   = 65;
  localparam int BUS_LO_WE   = 64;
  localparam int BUS_HI_MSB  = 63;
  localparam int BUS_HI_LSB  = 32;
  localparam int BUS_LO_MSB  = 31;
  localparam int BUS_LO_LSB  = 0;
  function automatic logic is_div_op(input logic [2:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic is_iter_op(input logic [2:0] op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction
  function automatic logic is_signed_op(input logic [2:0] op);
    return op == OP_MULT || op == OP_DIV;
  endfunction
endpackage

// File: rtl/hilo_div_core.sv
// hilo_div_core: restoring divider on unsigned magnitudes, one quotient bit per cycle
module hilo_div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         flush,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W);
  logic [CW-1:0] cnt;
  logic [W-1:0] d;
  logic [W:0] shifted, diff;
  // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
  assign shifted = {remainder, quotient[W-1]};
  assign diff = shifted - {1'b0, d};
  assign done = busy && cnt == CW'(W - 1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      busy <= 1'b0;
      cnt <= '0;
      d <= '0;
      quotient <= '0;
      remainder <= '0;
    end else if (flush) busy <= 1'b0;
    else if (start && !busy) begin
      busy <= 1'b1;
      cnt <= '0;
      d <= divisor;
      quotient <= dividend;
      remainder <= '0;
    end else if (busy) begin
      remainder <= diff[W] ? shifted[W-1:0] : diff[W-1:0];
      quotient <= {quotient[W-2:0], !diff[W]};
      cnt <= cnt + CW'(1);
      busy <= !done;
    end
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MULT/MULTU/DIV/DIVU and pass-through MTHI/MTLO driving the HI/LO write bus
// HILO_FAST_MUL_EN: multiply uses a combinational W x W multiplier and finishes one cycle after start
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [W-1:0]   src1,
  input  logic [W-1:0]   src2,
  input  logic           flush,
  output logic           stallreq,
  output logic [2*W+1:0] hilo_bus
);
  localparam int ITER = W;
  localparam int CW = $clog2(ITER);
  logic [1:0] st;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [W-1:0] s1_q, a, mag1, mag2, dq, dr, quot, rem;
  logic [2*W-1:0] p, p_init, prod;
  logic [W:0] sum;
  logic neg_q, neg_r, div0, sgn, go, fast, last, div_busy, div_done;
  assign sgn = is_signed_op(op);
  assign mag1 = sgn && src1[W-1] ? -src1 : src1;
  assign mag2 = sgn && src2[W-1] ? -src2 : src2;
  assign go = st == S_IDLE && start && !flush && is_iter_op(op);
`ifdef HILO_FAST_MUL_EN
  assign fast = !is_div_op(op);
  assign p_init = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
`else
  assign fast = 1'b0;
  assign p_init = {{W{1'b0}}, mag2};
`endif
  // shift-add: multiplier sits in the low half and shifts out as the product shifts in
  assign sum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : '0);
  assign last = is_div_op(op_q) ? div_done : cnt == CW'(ITER - 1);
  assign prod = neg_q ? -p : p;
  assign quot = div0 ? '1 : neg_q ? -dq : dq;
  assign rem = div0 ? s1_q : neg_r ? -dr : dr;
  assign stallreq = resetn && !flush && (go || st == S_BUSY || div_busy);
  assign hilo_bus = !resetn || flush ? '0 :
                    st == S_DONE ? {2'b11, is_div_op(op_q) ? {rem, quot} : prod} :
                    st == S_IDLE && start && op == OP_MTHI ? {2'b10, src1, {W{1'b0}}} :
                    st == S_IDLE && start && op == OP_MTLO ? {2'b01, {W{1'b0}}, src1} : '0;
  hilo_div_core #(.W(W)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .start    (go && is_div_op(op)),
    .flush    (flush),
    .dividend (mag1),
    .divisor  (mag2),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (dq),
    .remainder(dr)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      st <= S_IDLE;
      cnt <= '0;
      op_q <= OP_NOP;
      s1_q <= '0;
      a <= '0;
      p <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0 <= 1'b0;
    end else if (flush) st <= S_IDLE;
    else if (st == S_IDLE) begin
      if (go) begin
        st <= fast ? S_DONE : S_BUSY;
        cnt <= '0;
        op_q <= op;
        s1_q <= src1;
        a <= mag1;
        p <= p_init;
        neg_q <= sgn && (src1[W-1] ^ src2[W-1]);
        neg_r <= sgn && src1[W-1];
        div0 <= src2 == '0;
      end
    end else if (st == S_BUSY) begin
      cnt <= cnt + CW'(1);
      p <= {sum, p[W-1:1]};
      st <= last ? S_DONE : S_BUSY;
    end else st <= S_IDLE;
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed self-checking bench for hilo_muldiv
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;
`ifdef HILO_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, flush = 1'b0, stallreq;
  logic [2:0] op = OP_NOP;
  logic [31:0] src1 = '0, src2 = '0;
  logic [65:0] hilo_bus;
  int total = 0, bad = 0;
  hilo_muldiv dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .flush   (flush),
    .stallreq(stallreq),
    .hilo_bus(hilo_bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [63:0] want, input bit fl_done);
    int n = 0, nz = 0;
    @(negedge clk);
    start = 1'b1;
    op = o;
    src1 = x;
    src2 = y;
    #1;
    while (stallreq === 1'b1 && n < 40) begin
      n++;
      if (hilo_bus !== '0) nz++;
      @(negedge clk);
      #1;
    end
    chk({tag, " stall_cycles"}, 66'(n), 66'(lat));
    chk({tag, " bus_during_stall"}, 66'(nz), 66'd0);
    if (fl_done) begin
      flush = 1'b1;
      #1;
      chk({tag, " done_flushed"}, hilo_bus, '0);
    end else chk({tag, " result"}, hilo_bus, {2'b11, want});
    @(negedge clk);
    start = 1'b0;
    op = OP_NOP;
    flush = 1'b0;
    #1;
    chk({tag, " bus_after"}, hilo_bus, '0);
    chk({tag, " stall_after"}, 66'(stallreq), 66'd0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    start = 1'b1;
    op = OP_MTHI;
    src1 = 32'hDEADBEEF;
    #1;
    chk("reset bus", hilo_bus, '0);
    chk("reset stall", 66'(stallreq), 66'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    start = 1'b0;
    op = OP_NOP;
    #1;
    chk("idle bus", hilo_bus, '0);
    do_op("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 64'hFFFFFFFE_00000001, 1'b0);
    do_op("mult -3x7", OP_MULT, 32'hFFFFFFFD, 32'd7, MUL_LAT, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
    do_op("mult min*min", OP_MULT, 32'h80000000, 32'h80000000, MUL_LAT, 64'h40000000_00000000, 1'b0);
    do_op("mult min*1", OP_MULT, 32'h80000000, 32'd1, MUL_LAT, 64'hFFFFFFFF_80000000, 1'b0);
    do_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, DIV_LAT, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    do_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, DIV_LAT, 64'h00000001_FFFFFFFD, 1'b0);
    do_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, DIV_LAT, 64'h00000002_0000000E, 1'b0);
    do_op("divu by0", OP_DIVU, 32'h00001234, 32'd0, DIV_LAT, 64'h00001234_FFFFFFFF, 1'b0);
    do_op("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_LAT, 64'h00000000_80000000, 1'b0);
    do_op("div -7/0", OP_DIV, 32'hFFFFFFF9, 32'd0, DIV_LAT, 64'hFFFFFFF9_FFFFFFFF, 1'b0);
    do_op("divu flush done", OP_DIVU, 32'd100, 32'd7, DIV_LAT, 64'h0, 1'b1);
    @(negedge clk);
    start = 1'b1;
    op = OP_MTHI;
    src1 = 32'hDEADBEEF;
    #1;
    chk("mthi bus", hilo_bus, {2'b10, 32'hDEADBEEF, 32'h0});
    chk("mthi stall", 66'(stallreq), 66'd0);
    @(negedge clk);
    op = OP_MTLO;
    src1 = 32'd5;
    #1;
    chk("mtlo bus", hilo_bus, {2'b01, 32'h0, 32'd5});
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("mtlo flush bus", hilo_bus, '0);
    @(negedge clk);
    flush = 1'b0;
    op = 3'b111;
    #1;
    chk("reserved bus", hilo_bus, '0);
    chk("reserved stall", 66'(stallreq), 66'd0);
    @(negedge clk);
    op = OP_DIV;
    src1 = 32'hFFFFFFF9;
    src2 = 32'd2;
    repeat (10) @(negedge clk);
    #1;
    chk("busy stall", 66'(stallreq), 66'd1);
    flush = 1'b1;
    #1;
    chk("flush stall", 66'(stallreq), 66'd0);
    chk("flush bus", hilo_bus, '0);
    @(negedge clk);
    flush = 1'b0;
    start = 1'b0;
    op = OP_NOP;
    #1;
    chk("post flush stall", 66'(stallreq), 66'd0);
    chk("post flush bus", hilo_bus, '0);
    do_op("divu 9/3", OP_DIVU, 32'd9, 32'd3, DIV_LAT, 64'h00000000_00000003, 1'b0);
    @(negedge clk);
    start = 1'b1;
    op = OP_DIVU;
    src1 = 32'd100;
    src2 = 32'd7;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mid reset bus", hilo_bus, '0);
    chk("mid reset stall", 66'(stallreq), 66'd0);
    @(negedge clk);
    resetn = 1'b1;
    start = 1'b0;
    op = OP_NOP;
    #1;
    chk("after reset stall", 66'(stallreq), 66'd0);
    @(negedge clk);
    start = 1'b1;
    op = OP_MTLO;
    src1 = 32'd5;
    #1;
    chk("after reset mtlo", hilo_bus, {2'b01, 32'h0, 32'd5});
    @(negedge clk);
    start = 1'b0;
    op = OP_NOP;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
